// File: rtl/prime_trial_sequencer_if.sv
// -----------------------------------------------------------------------------
// prime_trial_sequencer_if
//   Request/result bundle between the user input logic (master) and the
//   trial-division sequencer (slave).
//
//   start    : request a primality test of n (master -> slave)
//   n        : candidate value, WIDTH bits (master -> slave)
//   abort    : cancel the run in progress (master -> slave)
//   busy     : run in progress, through the done cycle (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   is_prime : result flag, held until next accepted start or abort
//   factor   : smallest factor when composite, else 0, held like is_prime
// -----------------------------------------------------------------------------
interface prime_trial_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] n;
  logic             abort;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic [WIDTH-1:0] factor;

  modport master (
    output start, n, abort,
    input  busy, done, is_prime, factor
  );

  modport slave (
    input  start, n, abort,
    output busy, done, is_prime, factor
  );
endinterface

// File: rtl/prime_trial_sequencer.sv
// -----------------------------------------------------------------------------
// prime_trial_sequencer
//   Trial-division primality tester for one unsigned WIDTH-bit candidate.
//   Trivial candidates (0, 1, 2, 3, even) are resolved immediately. Otherwise
//   odd divisors d = 3, 5, 7, ... are tried, one per rising edge of slow_clk.
//   Each trial first checks d*d > n (prime), else runs a WIDTH-cycle restoring
//   remainder of n by d; a zero remainder reports d as the smallest factor.
//
//   clk      : system clock, all logic on posedge
//   rst_n    : asynchronous active-low reset
//   slow_clk : slow square wave, used only to pace divisor steps
//   bus      : slave side of prime_trial_sequencer_if
//              (start, n, abort in; busy, done, is_prime, factor out)
// -----------------------------------------------------------------------------
module prime_trial_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   slow_clk,
  prime_trial_sequencer_if.slave bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] D_FIRST  = WIDTH'(3);
  localparam logic [WIDTH-1:0] D_STEP   = WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLASSIFY  = 3'd1,
    S_WAIT_STEP = 3'd2,
    S_DIVIDE    = 3'd3,
    S_DECIDE    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic             step_s;

  logic [WIDTH-1:0] n_reg_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dividend_r;
  logic [CNT_W-1:0] cnt_r;

  logic             busy_r;
  logic             done_r;
  logic             is_prime_r;
  logic [WIDTH-1:0] factor_r;

  logic             accept_s;
  logic             abort_hit_s;
  logic             n_small_s;
  logic             n_tiny_prime_s;
  logic             n_even_s;
  logic [2*WIDTH-1:0] sq_s;
  logic             sq_gt_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   d_ext_s;
  logic             rem_ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic             div_last_s;
  logic             rem_zero_s;

  // A start landing on the done cycle sees busy=1 and is ignored, even though
  // the state register has already returned to IDLE.
  assign accept_s    = (state_r == S_IDLE) && bus.start && !busy_r;
  assign abort_hit_s = (state_r != S_IDLE) && bus.abort;

  assign step_s         = sync2_r & ~prev_r;
  assign n_small_s      = (n_reg_r < WIDTH'(2));
  assign n_tiny_prime_s = (n_reg_r == WIDTH'(2)) || (n_reg_r == WIDTH'(3));
  assign n_even_s       = (n_reg_r[0] == 1'b0);

  // Full double-width square so the bound compare can never wrap.
  assign sq_s    = {{WIDTH{1'b0}}, d_r} * {{WIDTH{1'b0}}, d_r};
  assign sq_gt_s = (sq_s > {{WIDTH{1'b0}}, n_reg_r});

  // One restoring step: bring in the next dividend bit, subtract d if it fits.
  // The partial remainder is always < d, so WIDTH bits hold the result.
  assign rem_shift_s = {rem_r, dividend_r[WIDTH-1]};
  assign d_ext_s     = {1'b0, d_r};
  assign rem_ge_s    = (rem_shift_s >= d_ext_s);
  assign rem_next_s  = WIDTH'(rem_ge_s ? (rem_shift_s - d_ext_s) : rem_shift_s);
  assign div_last_s  = (cnt_r == CNT_LAST);
  assign rem_zero_s  = (rem_r == {WIDTH{1'b0}});

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; abort overrides every other transition.
  always_comb begin
    state_next_s = state_r;
    if (abort_hit_s) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_next_s = S_CLASSIFY;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_CLASSIFY: begin
          if (n_small_s || n_tiny_prime_s || n_even_s) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_WAIT_STEP;
          end
        end
        S_WAIT_STEP: begin
          if (step_s && sq_gt_s) begin
            state_next_s = S_DONE;
          end else if (step_s) begin
            state_next_s = S_DIVIDE;
          end else begin
            state_next_s = S_WAIT_STEP;
          end
        end
        S_DIVIDE: begin
          if (div_last_s) begin
            state_next_s = S_DECIDE;
          end else begin
            state_next_s = S_DIVIDE;
          end
        end
        S_DECIDE: begin
          if (rem_zero_s) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_WAIT_STEP;
          end
        end
        S_DONE: begin
          state_next_s = S_IDLE;
        end
        default: begin
          state_next_s = S_IDLE;
        end
      endcase
    end
  end

  // slow_clk synchroniser plus previous-value register for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= slow_clk;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // busy/done are one cycle behind the state so that done lands two cycles
  // after the start-sampling edge and busy still covers the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (abort_hit_s) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != S_IDLE) || (state_r == S_DONE);
      done_r <= (state_r == S_DONE);
    end
  end

  // Result registers: cleared on accepted start or abort, set when a decision
  // is reached and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_prime_r <= 1'b0;
      factor_r   <= {WIDTH{1'b0}};
    end else if (abort_hit_s) begin
      is_prime_r <= 1'b0;
      factor_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            is_prime_r <= 1'b0;
            factor_r   <= {WIDTH{1'b0}};
          end
        end
        S_CLASSIFY: begin
          if (n_small_s) begin
            is_prime_r <= 1'b0;
            factor_r   <= {WIDTH{1'b0}};
          end else if (n_tiny_prime_s) begin
            is_prime_r <= 1'b1;
            factor_r   <= {WIDTH{1'b0}};
          end else if (n_even_s) begin
            is_prime_r <= 1'b0;
            factor_r   <= WIDTH'(2);
          end
        end
        S_WAIT_STEP: begin
          if (step_s && sq_gt_s) begin
            is_prime_r <= 1'b1;
            factor_r   <= {WIDTH{1'b0}};
          end
        end
        S_DECIDE: begin
          if (rem_zero_s) begin
            is_prime_r <= 1'b0;
            factor_r   <= d_r;
          end
        end
        default: begin
          is_prime_r <= is_prime_r;
          factor_r   <= factor_r;
        end
      endcase
    end
  end

  // Candidate latch, divisor schedule and restoring-remainder datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg_r    <= {WIDTH{1'b0}};
      d_r        <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      dividend_r <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else if (!abort_hit_s) begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            n_reg_r <= bus.n;
          end
        end
        S_CLASSIFY: begin
          d_r <= D_FIRST;
        end
        S_WAIT_STEP: begin
          if (step_s && !sq_gt_s) begin
            rem_r      <= {WIDTH{1'b0}};
            dividend_r <= n_reg_r;
            cnt_r      <= {CNT_W{1'b0}};
          end
        end
        S_DIVIDE: begin
          rem_r      <= rem_next_s;
          dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
          cnt_r      <= cnt_r + CNT_W'(1);
        end
        S_DECIDE: begin
          if (!rem_zero_s) begin
            d_r <= d_r + D_STEP;
          end
        end
        default: begin
          d_r <= d_r;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.is_prime = is_prime_r;
  assign bus.factor   = factor_r;

endmodule

// File: tb/tb_prime_trial_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prime_trial_sequencer
//   Directed-vector bench for prime_trial_sequencer (WIDTH=16). slow_clk is
//   driven by the bench as one rising edge per 30 clk so every divisor step
//   completes before the next edge.
// -----------------------------------------------------------------------------
module tb_prime_trial_sequencer;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  logic slow_clk;

  prime_trial_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

  prime_trial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .bus      (bus_if.slave)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  int cyc = 0;
  int edges_sent = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int edges_at_done = 0;
  logic res_prime = 1'b0;
  logic [WIDTH-1:0] res_factor = '0;
  logic busy_after = 1'b1;
  logic pend_busy = 1'b0;

  logic [WIDTH-1:0] triv_n [4] = '{16'd0, 16'd1, 16'd2, 16'd100};
  logic             triv_p [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [WIDTH-1:0] triv_f [4] = '{16'd0, 16'd0, 16'd0, 16'd2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe done pulses and the busy level one cycle later.
  always @(negedge clk) begin
    if (pend_busy) begin
      busy_after = bus_if.busy;
      pend_busy  = 1'b0;
    end
    if (bus_if.done === 1'b1) begin
      done_cnt      = done_cnt + 1;
      done_cyc      = cyc;
      edges_at_done = edges_sent;
      res_prime     = bus_if.is_prime;
      res_factor    = bus_if.factor;
      pend_busy     = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [WIDTH-1:0] val);
    @(negedge clk);
    bus_if.n     = val;
    bus_if.start = 1'b1;
    @(negedge clk);
    start_cyc    = cyc;
    bus_if.start = 1'b0;
    bus_if.n     = 16'hFFFF;
  endtask

  task automatic slow_pulses(input int k);
    for (int i = 0; i < k; i++) begin
      slow_clk   = 1'b1;
      edges_sent = edges_sent + 1;
      repeat (10) @(negedge clk);
      slow_clk = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  int d0;

  initial begin
    rst_n        = 1'b0;
    slow_clk     = 1'b0;
    bus_if.start = 1'b0;
    bus_if.n     = '0;
    bus_if.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset_outputs", {13'd0, bus_if.busy, bus_if.done, bus_if.is_prime, bus_if.factor}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("idle_busy", {31'd0, bus_if.busy}, 32'd0);

    // Trivial candidates: slow_clk stays low.
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      do_start(triv_n[i]);
      repeat (4) @(negedge clk);
      chk_eq("triv_done_count", done_cnt - d0, 32'd1);
      chk_eq("triv_latency", done_cyc - start_cyc, 32'd2);
      chk_eq("triv_is_prime", {31'd0, res_prime}, {31'd0, triv_p[i]});
      chk_eq("triv_factor", {16'd0, res_factor}, {16'd0, triv_f[i]});
    end

    // n=97: divisions at 3,5,7,9; fifth step sees 121 > 97.
    d0 = done_cnt;
    edges_sent = 0;
    do_start(16'd97);
    slow_pulses(4);
    chk_eq("p97_no_early_done", done_cnt - d0, 32'd0);
    chk_eq("p97_busy_mid", {31'd0, bus_if.busy}, 32'd1);
    slow_pulses(1);
    chk_eq("p97_done_count", done_cnt - d0, 32'd1);
    chk_eq("p97_done_edge", edges_at_done, 32'd5);
    chk_eq("p97_is_prime", {31'd0, res_prime}, 32'd1);
    chk_eq("p97_factor", {16'd0, res_factor}, 32'd0);

    // n=91: 7 divides on the third step.
    d0 = done_cnt;
    edges_sent = 0;
    busy_after = 1'b1;
    do_start(16'd91);
    slow_pulses(3);
    chk_eq("p91_done_count", done_cnt - d0, 32'd1);
    chk_eq("p91_done_edge", edges_at_done, 32'd3);
    chk_eq("p91_is_prime", {31'd0, res_prime}, 32'd0);
    chk_eq("p91_factor", {16'd0, res_factor}, 32'd7);
    chk_eq("p91_busy_after_done", {31'd0, busy_after}, 32'd0);

    // n=65521 with a second start (n=4) while busy; d runs to 257.
    d0 = done_cnt;
    edges_sent = 0;
    do_start(16'd65521);
    slow_pulses(3);
    do_start(16'd4);
    slow_pulses(125);
    chk_eq("busy_start_done_count", done_cnt - d0, 32'd1);
    chk_eq("busy_start_done_edge", edges_at_done, 32'd128);
    chk_eq("busy_start_is_prime", {31'd0, res_prime}, 32'd1);
    chk_eq("busy_start_factor", {16'd0, res_factor}, 32'd0);

    // Abort after 10 steps of n=65521.
    d0 = done_cnt;
    do_start(16'd65521);
    slow_pulses(10);
    chk_eq("abort_busy_before", {31'd0, bus_if.busy}, 32'd1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    chk_eq("abort_busy_after", {31'd0, bus_if.busy}, 32'd0);
    chk_eq("abort_is_prime", {31'd0, bus_if.is_prime}, 32'd0);
    chk_eq("abort_factor", {16'd0, bus_if.factor}, 32'd0);
    slow_pulses(3);
    chk_eq("abort_no_done", done_cnt - d0, 32'd0);
    d0 = done_cnt;
    do_start(16'd9);
    slow_pulses(1);
    chk_eq("after_abort_done_count", done_cnt - d0, 32'd1);
    chk_eq("after_abort_is_prime", {31'd0, res_prime}, 32'd0);
    chk_eq("after_abort_factor", {16'd0, res_factor}, 32'd3);

    // Async reset while dividing n=91, released with slow_clk high.
    d0 = done_cnt;
    do_start(16'd91);
    slow_clk   = 1'b1;
    edges_sent = edges_sent + 1;
    repeat (8) @(negedge clk);
    chk_eq("rst_mid_busy_before", {31'd0, bus_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst_mid_outputs", {13'd0, bus_if.busy, bus_if.done, bus_if.is_prime, bus_if.factor}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_eq("rst_release_busy", {31'd0, bus_if.busy}, 32'd0);
    chk_eq("rst_release_no_done", done_cnt - d0, 32'd0);
    slow_clk = 1'b0;
    repeat (5) @(negedge clk);
    edges_sent = 0;
    do_start(16'd91);
    slow_pulses(3);
    chk_eq("rst_rerun_done_count", done_cnt - d0, 32'd1);
    chk_eq("rst_rerun_factor", {16'd0, res_factor}, 32'd7);
    chk_eq("rst_rerun_is_prime", {31'd0, res_prime}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/prime_trial_sequencer.md
Name: prime_trial_sequencer

Overview:
Sequences trial-division primality testing of one unsigned candidate, one divisor step per rising edge of the 10 kHz slow clock. Each step runs a restoring-remainder datapath on the fast clock and stops at the first factor found, or when d*d > n. It sits between the user input logic and the result display, and owns the square-root bound and divisor schedule.

Parameters:
WIDTH, 16, candidate width in bits; also the number of remainder-unit cycles per divisor.

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
slow_clk  input  1  10 kHz square wave from the clock divider, used only as a step pacer
start  input  1  request a test of n; sampled only while busy=0
n  input  WIDTH  candidate, latched on accepted start
abort  input  1  cancel the run in progress
busy  output  1  high from the cycle after an accepted start through the done cycle
done  output  1  one-cycle pulse when the result is valid
is_prime  output  1  result; held until the next accepted start or abort
factor  output  WIDTH  smallest factor if composite, else 0; held like is_prime

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, is_prime, factor, slow_clk sync/edge registers, n_reg, d and remainder all 0.
- Step detection: slow_clk passes through a 2-flop synchroniser, then prev register. step = sync & ~prev.
  - Step is used only in WAIT_STEP. Steps in any other state are dropped, not queued.
- States:
  - IDLE: start=1 latches n into n_reg, clears is_prime and factor, goes to CLASSIFY.
  - CLASSIFY (1 cycle):
    - n_reg<2: not prime, factor 0, go to DONE.
    - n_reg=2 or 3: prime, go to DONE.
    - n_reg even (>2): not prime, factor=2, go to DONE.
    - Otherwise: d=3, go to WAIT_STEP.
  - WAIT_STEP: on step, compare d*d (2*WIDTH-bit product, no truncation) against n_reg.
    - d*d > n_reg: prime, go to DONE.
    - Otherwise go to DIVIDE.
  - DIVIDE: restoring shift-subtract of n_reg by d, exactly WIDTH cycles, then go to DECIDE.
  - DECIDE (1 cycle):
    - Remainder 0: not prime, factor=d, go to DONE.
    - Otherwise d=d+2, go to WAIT_STEP.
  - DONE (1 cycle): done=1, busy=1, then go to IDLE with busy=0.
- Latency:
  - Trivial cases: done asserted exactly 2 clk after the start-sampling edge. No slow_clk dependence.
  - Non-trivial cases: one step per slow_clk rising edge. The first step is the first edge detected after entering WAIT_STEP.
- Width and overflow: d is WIDTH bits. The loop always terminates before d exceeds 2^(WIDTH/2)+1, so d never wraps.
- start while busy=1: ignored, with no effect on the run.
- start in the same cycle as done: ignored, because busy=1 then. It is accepted the following cycle.
- abort: valid in any non-IDLE state.
  - Next cycle: state IDLE, busy=0, is_prime=0, factor=0, no done pulse.
  - abort has priority over every transition in that cycle.
  - abort in IDLE has no effect.
- Reset mid-run: immediate return to the reset values, with no done pulse.
- n input may change freely after the accepted start; only n_reg is used.

Test Plan:
- n=97, WIDTH=16:
  - Divisions at d=3,5,7,9; the 5th step sees 121>97.
  - Required: done, is_prime=1, factor=0.
  - No done before the 5th detected slow_clk edge.
- n=91: 3rd step (d=7) remainder 0 -> done, is_prime=0, factor=7. busy drops the cycle after done.
- Trivial cases: n=0, 1, 2, 100.
  - Required: done exactly 2 clk after start, slow_clk held low throughout.
  - Results (is_prime/factor): 0/0, 0/0, 1/0, 0/2.
- Start while busy: start n=65521, then pulse start with n=4 at step 3.
  - Required: run continues; done arrives with is_prime=1 after d reaches 257 (257*257 > 65521).
- Abort: n=65521, assert abort after 10 steps.
  - Required: busy=0 next cycle, no done pulse ever, is_prime=0.
  - A new start n=9 then gives factor=3.
- Async reset mid-run: drop rst_n during DIVIDE at n=91.
  - Required: all outputs 0 immediately.
  - A start after release behaves normally, and a slow_clk high at release causes no action in IDLE.
